// File: rtl/sbus_pkg.sv
// Shared definitions for the SBUS frame decoder: FSM states, default framing
// bytes and the bit positions inside the flags byte.
package sbus_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        FLAGS   = 2'd2,
        FOOT    = 2'd3
    } sbus_state_e;

    localparam logic [7:0] SBUS_HEADER = 8'h0F;
    localparam logic [7:0] SBUS_FOOTER = 8'h00;

    localparam int FLAG_CH17     = 0;
    localparam int FLAG_CH18     = 1;
    localparam int FLAG_LOST     = 2;
    localparam int FLAG_FAILSAFE = 3;

endpackage

// File: rtl/sbus_gap_timer.sv
// Inter-byte idle counter; expire fires on the idle cycle that would bring the
// count up to GAP_CYCLES. A byte arriving in that same cycle wins over expiry.
module sbus_gap_timer #(
    parameter int GAP_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = $clog2(GAP_CYCLES + 1);

    logic [CNT_W-1:0] count_r;

    assign expire = enable && !clear && (count_r == CNT_W'(GAP_CYCLES - 1));

    // Idle cycle counter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_r <= '0;
        end else if (clear || expire) begin
            count_r <= '0;
        end else if (enable) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/sbus_frame_decoder.sv
// SBUS frame decoder: hunts for the header, collects payload and flags into
// shadow registers and publishes them only when a correct footer arrives.
module sbus_frame_decoder
    import sbus_pkg::*;
#(
    parameter int         NUM_CH     = 16,
    parameter int         CH_BITS    = 11,
    parameter logic [7:0] HEADER     = SBUS_HEADER,
    parameter logic [7:0] FOOTER     = SBUS_FOOTER,
    parameter int         GAP_CYCLES = 1000
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [7:0]                byte_in,
    input  logic                      byte_valid,
    output logic [NUM_CH*CH_BITS-1:0] channels,
    output logic                      ch17,
    output logic                      ch18,
    output logic                      frame_lost,
    output logic                      failsafe,
    output logic                      frame_valid,
    output logic                      frame_err,
    output logic [15:0]               frame_count
);

    localparam int FRAME_BITS    = NUM_CH * CH_BITS;
    localparam int PAYLOAD_BYTES = FRAME_BITS / 8;
    localparam int IDX_W         = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;

    sbus_state_e             state_r, state_nx_s;
    logic [IDX_W-1:0]        idx_r;
    logic [FRAME_BITS-1:0]   shadow_r;
    logic [3:0]              shadow_flags_r;
    logic [FRAME_BITS-1:0]   channels_r;
    logic [3:0]              flags_r;
    logic                    frame_valid_r;
    logic                    frame_err_r;
    logic [15:0]             frame_count_r;

    logic load_payload_s, load_flags_s, commit_s, err_s, idx_clr_s;
    logic gap_clr_s, gap_en_s, gap_expire_s;

    assign gap_en_s  = (state_r != HUNT);
    assign gap_clr_s = byte_valid || !gap_en_s;

    sbus_gap_timer #(
        .GAP_CYCLES (GAP_CYCLES)
    ) u_gap_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (gap_clr_s),
        .enable  (gap_en_s),
        .expire  (gap_expire_s)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= HUNT;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_nx_s     = state_r;
        load_payload_s = 1'b0;
        load_flags_s   = 1'b0;
        commit_s       = 1'b0;
        err_s          = 1'b0;
        idx_clr_s      = 1'b0;
        if (byte_valid) begin
            case (state_r)
                HUNT: begin
                    if (byte_in == HEADER) begin
                        idx_clr_s  = 1'b1;
                        state_nx_s = PAYLOAD;
                    end else begin
                        state_nx_s = HUNT;
                    end
                end
                PAYLOAD: begin
                    load_payload_s = 1'b1;
                    if (idx_r == IDX_W'(PAYLOAD_BYTES - 1)) begin
                        state_nx_s = FLAGS;
                    end else begin
                        state_nx_s = PAYLOAD;
                    end
                end
                FLAGS: begin
                    load_flags_s = 1'b1;
                    state_nx_s   = FOOT;
                end
                FOOT: begin
                    if (byte_in == FOOTER) begin
                        commit_s = 1'b1;
                    end else begin
                        err_s = 1'b1;
                    end
                    state_nx_s = HUNT;
                end
                default: begin
                    state_nx_s = HUNT;
                end
            endcase
        end else if (gap_expire_s) begin
            err_s      = 1'b1;
            state_nx_s = HUNT;
        end else begin
            state_nx_s = state_r;
        end
    end

    // Shadow capture of the frame in progress
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idx_r          <= '0;
            shadow_r       <= '0;
            shadow_flags_r <= 4'h0;
        end else begin
            if (idx_clr_s) begin
                idx_r <= '0;
            end else if (load_payload_s) begin
                shadow_r[{idx_r, 3'b000} +: 8] <= byte_in;
                idx_r                          <= idx_r + IDX_W'(1);
            end else begin
                idx_r <= idx_r;
            end
            if (load_flags_s) begin
                shadow_flags_r <= byte_in[3:0];
            end else begin
                shadow_flags_r <= shadow_flags_r;
            end
        end
    end

    // Published outputs change only on a committed frame
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            channels_r    <= '0;
            flags_r       <= 4'h0;
            frame_valid_r <= 1'b0;
            frame_err_r   <= 1'b0;
            frame_count_r <= 16'h0000;
        end else begin
            frame_valid_r <= commit_s;
            frame_err_r   <= err_s;
            if (commit_s) begin
                channels_r    <= shadow_r;
                flags_r       <= shadow_flags_r;
                frame_count_r <= frame_count_r + 16'h0001;
            end else begin
                channels_r    <= channels_r;
                flags_r       <= flags_r;
                frame_count_r <= frame_count_r;
            end
        end
    end

    assign channels    = channels_r;
    assign ch17        = flags_r[FLAG_CH17];
    assign ch18        = flags_r[FLAG_CH18];
    assign frame_lost  = flags_r[FLAG_LOST];
    assign failsafe    = flags_r[FLAG_FAILSAFE];
    assign frame_valid = frame_valid_r;
    assign frame_err   = frame_err_r;
    assign frame_count = frame_count_r;

endmodule

// File: doc/sbus_frame_decoder.md
SBUS_FRAME_DECODER -- requirements
Module: sbus_frame_decoder

Interface
REQ-001 SHALL have parameter NUM_CH, default 16: number of proportional channels per frame.
REQ-002 SHALL have parameter CH_BITS, default 11: bits per channel; NUM_CH*CH_BITS SHALL be a multiple of 8.
REQ-003 SHALL have parameter HEADER, default 8'h0F: frame start byte.
REQ-004 SHALL have parameter FOOTER, default 8'h00: frame end byte.
REQ-005 SHALL have parameter GAP_CYCLES, default 1000: maximum idle clocks between bytes within one frame.
REQ-006 clk  input  1  single clock; all logic on its rising edge.
REQ-007 reset_n  input  1  reset, synchronous, active-low.
REQ-008 byte_in  input  8  received UART byte, already inverted and parity-checked.
REQ-009 byte_valid  input  1  byte_in qualifier, one-cycle strobe per byte.
REQ-010 channels  output  NUM_CH*CH_BITS  decoded channels; channel k at bits [k*CH_BITS +: CH_BITS].
REQ-011 ch17, ch18  output  1 each  digital channels, flags bits 0 and 1.
REQ-012 frame_lost, failsafe  output  1 each  flags bits 2 and 3.
REQ-013 frame_valid  output  1  one-cycle pulse when a good frame is committed.
REQ-014 frame_err  output  1  one-cycle pulse on footer mismatch or gap timeout.
REQ-015 frame_count  output  16  count of committed frames.

Function
REQ-016 PAYLOAD_BYTES SHALL equal NUM_CH*CH_BITS/8 (22 at defaults).
REQ-017 FSM states SHALL be HUNT, PAYLOAD, FLAGS and FOOT; reset state SHALL be HUNT.
REQ-018 In HUNT, a byte equal to HEADER SHALL clear the byte index and go to PAYLOAD; any other byte SHALL be ignored.
REQ-019 In PAYLOAD, each byte SHALL be written to shadow bits [idx*8 +: 8], LSB-first little-endian; after byte PAYLOAD_BYTES-1 the FSM SHALL go to FLAGS.
REQ-020 In FLAGS, the byte SHALL be latched into a shadow flags register; the FSM SHALL then go to FOOT.
REQ-021 In FOOT, a byte equal to FOOTER SHALL copy shadow payload and flags to the outputs, pulse frame_valid, increment frame_count, and go to HUNT.
REQ-022 In FOOT, a byte not equal to FOOTER SHALL pulse frame_err, leave the outputs unchanged, and go to HUNT.
REQ-023 Outputs and frame_valid SHALL update in the cycle after the footer byte_valid, giving 1-cycle latency.
REQ-024 Outside HUNT, the gap counter SHALL clear on each byte_valid and increment otherwise; reaching GAP_CYCLES SHALL pulse frame_err and go to HUNT.
REQ-025 The gap counter SHALL stay cleared in HUNT.
REQ-026 When byte_valid and gap expiry occur in the same cycle, the byte SHALL be accepted and no timeout SHALL occur.
REQ-027 frame_count SHALL wrap from 16'hFFFF to 0.
REQ-028 Outputs SHALL hold the last good frame indefinitely; partial frames SHALL never be visible.
REQ-029 A HEADER-valued byte inside PAYLOAD or FLAGS SHALL be treated as data.

Reset
REQ-030 On reset_n low at a clock edge: FSM SHALL go to HUNT, and channels, flags outputs, frame_valid, frame_err, frame_count, gap counter, byte index and shadow registers SHALL all be 0.
REQ-031 Reset mid-frame SHALL discard the partial frame with no frame_err pulse.

Structure
REQ-032 A shared package sbus_pkg SHALL hold the FSM state enum, default HEADER and FOOTER constants, and flag bit positions.
REQ-033 A sub-module sbus_gap_timer (counter with clear, enable and expire outputs) SHALL implement the gap timeout.

Verification
REQ-034 All payload bytes 0xFF, flags 0x00, correct footer -> every channel 0x7FF, frame_valid one pulse, frame_count 1.
REQ-035 Channel 0 = 0x123, other channels 0 (bytes 0x23,0x01, then 20x 0x00), flags 0x0C -> channels[10:0]=0x123, failsafe=1, frame_lost=1, ch17=0.
REQ-036 Good frame, then frame with footer 0x55 -> frame_err pulse; outputs keep the first frame; frame_count stays 1.
REQ-037 Header plus 10 bytes, then GAP_CYCLES idle -> frame_err pulse in that cycle; a following good frame decodes correctly.
REQ-038 reset_n low after byte 5 of a frame -> all outputs 0 and no frame_err; the next full frame decodes correctly.
REQ-039 With NUM_CH=8, CH_BITS=12 (12 payload bytes) -> 12-bit channels decode LSB-first correctly.
